// File: rtl/shift_reg_univ_pkg.sv
// shift_reg_univ_pkg: mode encodings and burst FSM states for the universal shift register
package shift_reg_univ_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: free-running divider producing a registered one-CLK TICK every TICK_DIV cycles
module clk_tick_gen #(
    parameter int TICK_DIV = 33554432
) (
    input  logic CLK,
    input  logic R,
    output logic TICK
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cnt  <= '0;
            TICK <= 1'b0;
        end else begin
            cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
            TICK <= cnt == LAST;
        end
    end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with continuous mode and counted burst engine
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 33554432,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             CE,
    input  logic [2:0]       MODE,
    input  logic             SLI,
    input  logic             SRI,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT,
    output logic [WIDTH-1:0] Q,
    output logic             SLO,
    output logic             SRO,
    output logic             TICK,
    output logic             BUSY,
    output logic             DONE
);
    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [2:0]       mode_l, mode_n, sel;
    logic [WIDTH-1:0] q_n, shifted;
    logic             done_n;

    clk_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.CLK(CLK), .R(R), .TICK(TICK));

    assign SLO  = Q[WIDTH-1];
    assign SRO  = Q[0];
    assign BUSY = state == ST_RUN;

    always_comb begin
        sel     = state == ST_RUN ? mode_l : MODE;
        shifted = sel == MODE_SHL  ? {Q[WIDTH-2:0], SLI}      :
                  sel == MODE_SHR  ? {SRI, Q[WIDTH-1:1]}      :
                  sel == MODE_ROL  ? {Q[WIDTH-2:0], Q[WIDTH-1]} :
                  sel == MODE_ROR  ? {Q[0], Q[WIDTH-1:1]}     :
                  sel == MODE_LOAD ? D : Q;
        state_n = state;
        rem_n   = rem;
        mode_n  = mode_l;
        q_n     = Q;
        done_n  = 1'b0;
        if (state == ST_IDLE) begin
            // START wins over a continuous op on the same edge
            if (START) begin
                if (COUNT != '0) begin
                    state_n = ST_RUN;
                    rem_n   = COUNT;
                    mode_n  = MODE;
                end else begin
                    done_n = 1'b1;
                end
            end else if (TICK && CE) begin
                q_n = shifted;
            end
        end else if (TICK) begin
            q_n   = shifted;
            rem_n = rem - 1'b1;
            if (rem == CNT_W'(1)) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state  <= ST_IDLE;
            rem    <= '0;
            mode_l <= MODE_HOLD;
            Q      <= '0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            mode_l <= mode_n;
            Q      <= q_n;
            DONE   <= done_n;
        end
    end
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed self-checking bench for shift_reg_univ (WIDTH=4, TICK_DIV=4)
module tb_shift_reg_univ;
    logic       CLK = 1'b0;
    logic       R = 1'b1, CE = 1'b0, SLI = 1'b0, SRI = 1'b0, START = 1'b0;
    logic [2:0] MODE = 3'b000;
    logic [3:0] D = 4'b0000;
    logic [7:0] COUNT = 8'd0;
    logic [3:0] Q;
    logic       SLO, SRO, TICK, BUSY, DONE;
    int         n_tests = 0, n_fail = 0;

    shift_reg_univ #(.WIDTH(4), .TICK_DIV(4), .CNT_W(8)) dut (
        .CLK(CLK), .R(R), .CE(CE), .MODE(MODE), .SLI(SLI), .SRI(SRI), .D(D),
        .START(START), .COUNT(COUNT), .Q(Q), .SLO(SLO), .SRO(SRO),
        .TICK(TICK), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // leaves the bench just before a TICK-qualified edge
    task automatic wait_tick();
        int n = 0;
        while (!TICK && n < 10) begin
            step();
            n++;
        end
        if (!TICK) check("tick_wait", TICK, 1);
    endtask

    logic [3:0] shl_exp [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
    logic [3:0] rol_exp [3] = '{4'b0011, 4'b0110, 4'b1100};

    initial begin
        step();
        step();
        R = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            check($sformatf("rst_tick_c%0d", c), TICK, (c % 4) == 0);
            check($sformatf("rst_q_c%0d", c), Q, 0);
        end
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);

        CE = 1'b1;
        MODE = 3'b001;
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            SLI = i < 4;
            step();
            check($sformatf("shl_%0d", i), Q, shl_exp[i]);
        end
        check("slo", SLO, 1);
        check("sro", SRO, 0);
        CE = 1'b0;
        SLI = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick();
            step();
            check($sformatf("ce0_hold_%0d", i), Q, 4'b1100);
        end

        MODE = 3'b101;
        D = 4'b1001;
        CE = 1'b1;
        wait_tick();
        step();
        check("load", Q, 4'b1001);
        CE = 1'b0;
        START = 1'b1;
        MODE = 3'b011;
        COUNT = 8'd3;
        step();
        START = 1'b0;
        check("rol_busy_start", BUSY, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            check($sformatf("rol_busy_pre_%0d", i), BUSY, 1);
            check($sformatf("rol_done_pre_%0d", i), DONE, 0);
            step();
            check($sformatf("rol_q_%0d", i), Q, rol_exp[i]);
            check($sformatf("rol_busy_%0d", i), BUSY, i < 2);
            check($sformatf("rol_done_%0d", i), DONE, i == 2);
        end
        step();
        check("rol_done_width", DONE, 0);

        MODE = 3'b101;
        D = 4'b0000;
        CE = 1'b1;
        wait_tick();
        step();
        check("clear", Q, 4'b0000);
        CE = 1'b0;
        START = 1'b1;
        MODE = 3'b010;
        SRI = 1'b1;
        COUNT = 8'd2;
        step();
        MODE = 3'b001;
        CE = 1'b1;
        SLI = 1'b0;
        COUNT = 8'd5;
        wait_tick();
        step();
        check("iso_q0", Q, 4'b1000);
        check("iso_busy0", BUSY, 1);
        START = 1'b0;
        MODE = 3'b101;
        wait_tick();
        step();
        CE = 1'b0;
        check("iso_q1", Q, 4'b1100);
        check("iso_busy1", BUSY, 0);
        check("iso_done1", DONE, 1);
        step();

        START = 1'b1;
        COUNT = 8'd0;
        step();
        START = 1'b0;
        check("cnt0_done", DONE, 1);
        check("cnt0_busy", BUSY, 0);
        check("cnt0_q", Q, 4'b1100);
        step();
        check("cnt0_done_clr", DONE, 0);

        CE = 1'b1;
        MODE = 3'b001;
        SLI = 1'b1;
        wait_tick();
        START = 1'b1;
        COUNT = 8'd1;
        step();
        START = 1'b0;
        CE = 1'b0;
        check("coll_q", Q, 4'b1100);
        check("coll_busy", BUSY, 1);
        wait_tick();
        step();
        check("coll_burst_q", Q, 4'b1001);
        check("coll_burst_done", DONE, 1);
        step();

        START = 1'b1;
        MODE = 3'b001;
        SLI = 1'b0;
        COUNT = 8'd10;
        step();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            step();
        end
        check("mid_q_pre", Q, 4'b1000);
        check("mid_busy_pre", BUSY, 1);
        R = 1'b1;
        #1;
        check("mid_q_rst", Q, 0);
        check("mid_busy_rst", BUSY, 0);
        check("mid_done_rst", DONE, 0);
        step();
        R = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("mid_tick_c%0d", c), TICK, (c % 4) == 0);
            check($sformatf("mid_done_c%0d", c), DONE, 0);
            check($sformatf("mid_busy_c%0d", c), BUSY, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
